// File: rtl/alu_rhs_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter:
// function codes, requester id, response FIFO sizing and entry layout.
package alu_rhs_arbiter_pkg;

  // Function code: bit n is the result for operand bit pair {lhs,rhs} == n,
  // and drives the logic unit select line ACn_RHSn.
  typedef enum logic [3:0] {
    FUNC_ZERO     = 4'b0000,
    FUNC_AND      = 4'b1000,
    FUNC_OR       = 4'b1110,
    FUNC_XOR      = 4'b0110,
    FUNC_NOT_LHS  = 4'b0011,
    FUNC_PASS_LHS = 4'b1100,
    FUNC_PASS_RHS = 4'b1010,
    FUNC_ONES     = 4'b1111
  } alu_func_t;

  // 0 = main pipeline, 1 = auxiliary requester
  typedef logic req_id_t;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int RSP_PTR_W      = $clog2(RSP_FIFO_DEPTH);

  // One response: issuing requester and captured logic result
  typedef struct packed {
    req_id_t    id;
    logic [7:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/alu_rhs_arbiter_fifo.sv
// In-order response FIFO (depth 2, 9-bit {id, data} entries).
// The arbiter's credit scheme guarantees it never overflows.
module alu_rsp_fifo
  import alu_rhs_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [8:0]           push_data,
  input  logic                 pop,
  output logic                 head_valid,
  output logic [8:0]           head_data,
  output logic [RSP_CNT_W-1:0] count
);

  logic [8:0]           mem_reg [RSP_FIFO_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr_reg;
  logic [RSP_PTR_W-1:0] rd_ptr_reg;
  logic [RSP_CNT_W-1:0] count_reg;
  logic [RSP_CNT_W-1:0] count_next;
  logic                 pop_ok;

  assign pop_ok     = pop && (count_reg != '0);
  assign head_valid = (count_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

  // Storage slots; cleared on reset so the head reads as zero
  for (genvar gi = 0; gi < RSP_FIFO_DEPTH; gi++) begin : g_slot
    // Write this slot when the write pointer addresses it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == RSP_PTR_W'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // A push into a full FIFO means the upstream credit accounting is broken
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_reg == RSP_CNT_W'(RSP_FIFO_DEPTH))));

endmodule

// File: rtl/alu_rhs_arbiter.sv
// Round-robin arbiter sharing one combinational logic unit between a
// pipeline requester (0) and an auxiliary requester (1). Granted operands
// are registered onto the unit, an in-flight tracker follows each op for
// LATENCY+1 edges, and results land tagged in a 2-entry response FIFO.
// Issue is credit-limited to 2 outstanding ops (in flight + queued).
module alu_rhs_arbiter
  import alu_rhs_arbiter_pkg::*;
#(
  parameter int LATENCY = 1  // edges from operand drive until Logic is valid, 0..3
) (
  input  logic       AluClock,
  input  logic       nReset,
  input  logic       ReqValid0,
  input  logic       ReqValid1,
  output logic       ReqReady0,
  output logic       ReqReady1,
  input  logic [7:0] ReqLHS0,
  input  logic [7:0] ReqRHS0,
  input  logic [7:0] ReqLHS1,
  input  logic [7:0] ReqRHS1,
  input  logic [3:0] ReqFunc0,
  input  logic [3:0] ReqFunc1,
  output logic [7:0] LHS,
  output logic [7:0] RHS,
  output logic       AC0_RHS0,
  output logic       AC1_RHS1,
  output logic       AC2_RHS2,
  output logic       AC3_RHS3,
  input  logic [7:0] Logic,
  output logic       RspValid,
  input  logic       RspReady,
  output logic       RspId,
  output logic [7:0] RspData
);

  if (LATENCY < 0 || LATENCY > 3) begin : g_bad_latency
    $error("alu_rhs_arbiter: LATENCY must be in 0..3");
  end

  logic                 last_grant_reg;
  logic [7:0]           lhs_reg;
  logic [7:0]           rhs_reg;
  alu_func_t            func_reg;
  logic [LATENCY:0]     stage_valid_reg;
  logic [LATENCY:0]     stage_id_reg;

  logic [2:0]           inflight_count;
  logic [2:0]           occupancy;
  logic [RSP_CNT_W-1:0] fifo_count;
  logic                 credit_ok;
  logic                 grant0;
  logic                 grant1;
  logic                 grant_any;
  req_id_t              grant_id;
  rsp_entry_t           push_entry;
  rsp_entry_t           head_entry;
  logic                 fifo_push;
  logic                 fifo_pop;

  // Count ops still travelling through the logic unit
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i <= LATENCY; i++) begin
      inflight_count = inflight_count + 3'(stage_valid_reg[i]);
    end
  end

  // Credit comes from registered state only, so a pop frees it next cycle
  assign occupancy = 3'(fifo_count) + inflight_count;
  assign credit_ok = nReset && (occupancy < 3'(RSP_FIFO_DEPTH));

  // Each ready looks only at the other requester's valid, never its own.
  // On a tie the pointer hands the slot to whoever was not granted last.
  assign ReqReady0 = credit_ok && (!ReqValid1 || last_grant_reg);
  assign ReqReady1 = credit_ok && (!ReqValid0 || !last_grant_reg);

  assign grant0    = ReqValid0 && ReqReady0;
  assign grant1    = ReqValid1 && ReqReady1;
  assign grant_any = grant0 || grant1;
  assign grant_id  = grant1;

  // Drive granted operands/function to the logic unit and remember the winner
  always_ff @(posedge AluClock or negedge nReset) begin
    if (!nReset) begin
      lhs_reg        <= '0;
      rhs_reg        <= '0;
      func_reg       <= FUNC_ZERO;
      last_grant_reg <= 1'b1;
    end else if (grant_any) begin
      lhs_reg        <= grant1 ? ReqLHS1 : ReqLHS0;
      rhs_reg        <= grant1 ? ReqRHS1 : ReqRHS0;
      func_reg       <= alu_func_t'(grant1 ? ReqFunc1 : ReqFunc0);
      last_grant_reg <= grant_id;
    end
  end

  // In-flight tracker: stage 0 loads on issue, the last stage marks capture
  always_ff @(posedge AluClock or negedge nReset) begin
    if (!nReset) begin
      stage_valid_reg <= '0;
      stage_id_reg    <= '0;
    end else begin
      stage_valid_reg[0] <= grant_any;
      stage_id_reg[0]    <= grant_id;
      for (int i = 1; i <= LATENCY; i++) begin
        stage_valid_reg[i] <= stage_valid_reg[i-1];
        stage_id_reg[i]    <= stage_id_reg[i-1];
      end
    end
  end

  assign fifo_push  = stage_valid_reg[LATENCY];
  assign push_entry = '{id: stage_id_reg[LATENCY], data: Logic};
  assign fifo_pop   = RspValid && RspReady;

  alu_rsp_fifo u_rsp_fifo (
    .clk        (AluClock),
    .rst_n      (nReset),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .head_valid (RspValid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign RspId    = head_entry.id;
  assign RspData  = head_entry.data;
  assign LHS      = lhs_reg;
  assign RHS      = rhs_reg;
  assign AC0_RHS0 = func_reg[0];
  assign AC1_RHS1 = func_reg[1];
  assign AC2_RHS2 = func_reg[2];
  assign AC3_RHS3 = func_reg[3];

endmodule

// File: tb/tb_alu_rhs_arbiter.sv
// Directed bench for alu_rhs_arbiter. Three instances share one clock:
// index 0 uses LATENCY=1, index 1 LATENCY=0, index 2 LATENCY=3. Each has a
// behavioural logic unit whose result lags the operand registers by LATENCY.
module tb_alu_rhs_arbiter;
  import alu_rhs_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n      [3];
  logic       req_valid0 [3];
  logic       req_valid1 [3];
  wire        req_ready0 [3];
  wire        req_ready1 [3];
  logic [7:0] req_lhs0   [3];
  logic [7:0] req_rhs0   [3];
  logic [7:0] req_lhs1   [3];
  logic [7:0] req_rhs1   [3];
  logic [3:0] req_func0  [3];
  logic [3:0] req_func1  [3];
  wire  [7:0] lhs        [3];
  wire  [7:0] rhs        [3];
  wire  [3:0] ac         [3];
  wire  [7:0] logic_w    [3];
  wire        rsp_valid  [3];
  logic       rsp_ready  [3];
  wire        rsp_id     [3];
  wire  [7:0] rsp_data   [3];

  int tests_run    = 0;
  int tests_failed = 0;
  int rq_id   [$];
  int rq_data [$];

  // Reference logic unit: result bit i = f[{a[i], b[i]}]
  function automatic logic [7:0] lu_model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = f[{a[i], b[i]}];
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    wire       a0, a1, a2, a3;
    wire [7:0] lu_now;

    alu_rhs_arbiter #(.LATENCY(LAT)) u_dut (
      .AluClock (clk),
      .nReset   (rst_n[gi]),
      .ReqValid0(req_valid0[gi]),
      .ReqValid1(req_valid1[gi]),
      .ReqReady0(req_ready0[gi]),
      .ReqReady1(req_ready1[gi]),
      .ReqLHS0  (req_lhs0[gi]),
      .ReqRHS0  (req_rhs0[gi]),
      .ReqLHS1  (req_lhs1[gi]),
      .ReqRHS1  (req_rhs1[gi]),
      .ReqFunc0 (req_func0[gi]),
      .ReqFunc1 (req_func1[gi]),
      .LHS      (lhs[gi]),
      .RHS      (rhs[gi]),
      .AC0_RHS0 (a0),
      .AC1_RHS1 (a1),
      .AC2_RHS2 (a2),
      .AC3_RHS3 (a3),
      .Logic    (logic_w[gi]),
      .RspValid (rsp_valid[gi]),
      .RspReady (rsp_ready[gi]),
      .RspId    (rsp_id[gi]),
      .RspData  (rsp_data[gi])
    );

    assign ac[gi]  = {a3, a2, a1, a0};
    assign lu_now  = lu_model(lhs[gi], rhs[gi], ac[gi]);

    if (LAT == 0) begin : g_comb
      assign logic_w[gi] = lu_now;
    end else begin : g_pipe
      logic [7:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= lu_now;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign logic_w[gi] = pipe[LAT-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst_n[k]      = 1'b0;
    req_valid0[k] = 1'b0;
    req_valid1[k] = 1'b0;
    rsp_ready[k]  = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b1;
    tick();
  endtask

  // Pop responses into rq_id/rq_data until 'want' are collected or budget runs out
  task automatic collect(input int k, input int want, input int budget);
    rsp_ready[k] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (rq_data.size() >= want) break;
      #1;
      if (rsp_valid[k]) begin
        rq_id.push_back(int'(rsp_id[k]));
        rq_data.push_back(int'(rsp_data[k]));
      end
      tick();
    end
    rsp_ready[k] = 1'b0;
    check("collect_count", rq_data.size(), want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int n0, n1, ng, n, seen;
    int exp_gid [4];
    int exp_data [4];

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req_valid0[k] = 1'b0; req_valid1[k] = 1'b0;
      req_lhs0[k] = '0; req_rhs0[k] = '0; req_lhs1[k] = '0; req_rhs1[k] = '0;
      req_func0[k] = '0; req_func1[k] = '0;
      rsp_ready[k] = 1'b0;
    end

    // ---- reset state, with both requesters asserting valid ----
    #3;
    req_valid0[0] = 1'b1; req_valid1[0] = 1'b1;
    #1;
    check("rst_ready0", req_ready0[0], 0);
    check("rst_ready1", req_ready1[0], 0);
    check("rst_lhs", lhs[0], 0);
    check("rst_ac", ac[0], 0);
    check("rst_rspvalid", rsp_valid[0], 0);
    check("rst_rspdata", {rsp_id[0], rsp_data[0]}, 0);
    req_valid0[0] = 1'b0; req_valid1[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    tick();

    // ---- single op: 0xF0 AND 0x3C from requester 0 ----
    req_valid0[0] = 1'b1; req_lhs0[0] = 8'hF0; req_rhs0[0] = 8'h3C; req_func0[0] = FUNC_AND;
    #1;
    check("single_ready0", req_ready0[0], 1);
    tick();
    req_valid0[0] = 1'b0;
    check("single_lhs", lhs[0], 8'hF0);
    check("single_rhs", rhs[0], 8'h3C);
    check("single_ac", ac[0], 4'b1000);
    check("single_early0", rsp_valid[0], 0);
    tick();
    check("single_early1", rsp_valid[0], 0);
    tick();
    check("single_valid", rsp_valid[0], 1);
    check("single_id", rsp_id[0], 0);
    check("single_data", rsp_data[0], 8'h30);
    rsp_ready[0] = 1'b1;
    tick();
    check("single_popped", rsp_valid[0], 0);
    rsp_ready[0] = 1'b0;

    // ---- contention: both valid, grants must alternate 0,1,0,1 ----
    do_reset(0);
    rq_id.delete(); rq_data.delete();
    req_func0[0] = FUNC_PASS_LHS; req_func1[0] = FUNC_PASS_LHS;
    req_rhs0[0] = 8'h00; req_rhs1[0] = 8'h00;
    rsp_ready[0] = 1'b1;
    n0 = 0; n1 = 0; ng = 0;
    exp_gid  = '{0, 1, 0, 1};
    exp_data = '{8'h01, 8'h81, 8'h02, 8'h82};
    for (int c = 0; c < 40 && rq_data.size() < 4; c++) begin
      req_valid0[0] = (ng < 4);
      req_valid1[0] = (ng < 4);
      req_lhs0[0] = 8'(8'h01 + n0);
      req_lhs1[0] = 8'(8'h81 + n1);
      #1;
      if (req_valid0[0] && req_ready0[0] && req_valid1[0] && req_ready1[0])
        check("cont_double_grant", 1, 0);
      if (req_valid0[0] && req_ready0[0]) begin
        check($sformatf("cont_grant%0d", ng), 0, exp_gid[ng]);
        n0++; ng++;
      end else if (req_valid1[0] && req_ready1[0]) begin
        check($sformatf("cont_grant%0d", ng), 1, exp_gid[ng]);
        n1++; ng++;
      end
      if (rsp_valid[0]) begin
        rq_id.push_back(int'(rsp_id[0]));
        rq_data.push_back(int'(rsp_data[0]));
      end
      tick();
    end
    req_valid0[0] = 1'b0; req_valid1[0] = 1'b0; rsp_ready[0] = 1'b0;
    check("cont_ngrant", ng, 4);
    check("cont_nrsp", rq_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_rsp_id%0d", i), (i < rq_id.size()) ? rq_id[i] : -1, exp_gid[i]);
      check($sformatf("cont_rsp_data%0d", i), (i < rq_data.size()) ? rq_data[i] : -1, exp_data[i]);
    end

    // ---- backpressure: requester 1 streams XOR 0xFF with RspReady low ----
    do_reset(0);
    req_rhs1[0] = 8'hFF; req_func1[0] = FUNC_XOR;
    n1 = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid1[0] = 1'b1;
      req_lhs1[0] = 8'(8'h11 * (n1 + 1));
      #1;
      if (req_ready1[0]) n1++;
      tick();
    end
    #1;
    check("bp_accepted", n1, 2);
    check("bp_ready_low", req_ready1[0], 0);
    rsp_ready[0] = 1'b1;
    #1;
    check("bp_ready_same_cycle", req_ready1[0], 0);
    check("bp_head_data", rsp_data[0], 8'hEE);
    check("bp_head_id", rsp_id[0], 1);
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    check("bp_ready_after_pop", req_ready1[0], 1);
    tick();
    req_valid1[0] = 1'b0;
    #1;
    check("bp_ready_full_again", req_ready1[0], 0);
    check("bp_head2_data", rsp_data[0], 8'hDD);
    rq_id.delete(); rq_data.delete();
    collect(0, 2, 12);
    check("bp_drain0", (rq_data.size() > 0) ? rq_data[0] : -1, 8'hDD);
    check("bp_drain1", (rq_data.size() > 1) ? rq_data[1] : -1, 8'hCC);

    // ---- push and pop on the same edge with one entry queued ----
    do_reset(0);
    req_valid0[0] = 1'b1; req_lhs0[0] = 8'h11; req_rhs0[0] = 8'h00; req_func0[0] = FUNC_PASS_LHS;
    tick();
    req_lhs0[0] = 8'h22;
    tick();
    req_valid0[0] = 1'b0;
    tick();
    check("pp_first_valid", rsp_valid[0], 1);
    check("pp_first_data", rsp_data[0], 8'h11);
    rsp_ready[0] = 1'b1;
    tick();
    check("pp_after_valid", rsp_valid[0], 1);
    check("pp_after_data", rsp_data[0], 8'h22);
    tick();
    check("pp_empty", rsp_valid[0], 0);
    rsp_ready[0] = 1'b0;

    // ---- reset between issue and capture discards the op ----
    do_reset(0);
    req_valid0[0] = 1'b1; req_lhs0[0] = 8'hC3; req_rhs0[0] = 8'h5A; req_func0[0] = FUNC_ONES;
    tick();
    req_valid0[0] = 1'b0;
    check("rm_lhs_issued", lhs[0], 8'hC3);
    check("rm_ac_issued", ac[0], 4'hF);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("rm_lhs_zero", lhs[0], 0);
    check("rm_rhs_zero", rhs[0], 0);
    check("rm_ac_zero", ac[0], 0);
    check("rm_ready0", req_ready0[0], 0);
    check("rm_rsp_zero", {rsp_valid[0], rsp_id[0], rsp_data[0]}, 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rsp_valid[0]) seen++;
    end
    check("rm_no_response", seen, 0);

    // ---- latency sweep: LATENCY=0 and LATENCY=3 ----
    for (int k = 1; k < 3; k++) begin
      do_reset(k);
      req_valid0[k] = 1'b1; req_lhs0[k] = 8'h5A; req_rhs0[k] = 8'h0F; req_func0[k] = FUNC_AND;
      #1;
      check($sformatf("lat%0d_ready_e0", lat_of(k)), req_ready0[k], 1);
      tick();
      req_lhs0[k] = 8'hA5;
      #1;
      check($sformatf("lat%0d_ready_e1", lat_of(k)), req_ready0[k], 1);
      tick();
      req_valid0[k] = 1'b0;
      #1;
      check($sformatf("lat%0d_two_outstanding", lat_of(k)), req_ready0[k], 0);
      n = 1;
      while (!rsp_valid[k] && n < 12) begin
        tick();
        n++;
      end
      check($sformatf("lat%0d_capture_edge", lat_of(k)), n, lat_of(k) + 1);
      check($sformatf("lat%0d_id", lat_of(k)), rsp_id[k], 0);
      check($sformatf("lat%0d_data0", lat_of(k)), rsp_data[k], 8'h0A);
      rsp_ready[k] = 1'b1;
      tick();
      check($sformatf("lat%0d_valid1", lat_of(k)), rsp_valid[k], 1);
      check($sformatf("lat%0d_data1", lat_of(k)), rsp_data[k], 8'h05);
      tick();
      check($sformatf("lat%0d_drained", lat_of(k)), rsp_valid[k], 0);
      rsp_ready[k] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
